dmem_ctrl: RTL and testbench

- Parametrised data-memory controller between the MIPS core load/store port and an internal synchronous word RAM.
- Replaces the fixed always-write-all-lanes data RAM hookup with byte/halfword/word access, byte-lane write enables and load sign/zero extension.
- Adds configurable read latency with a req/ready/stall handshake and misalignment detection.
- Sits beside the core in the top level; the core freezes its pipeline while stall is high.

---
 rtl/dmem_ctrl.sv | 156 +++++++++++++++
 tb/tb_dmem_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// Data-memory controller: byte/half/word load-store onto a synchronous word RAM, RD_LAT-cycle loads, misalign detect.
// Define DMEM_PERF_CNT_EN to add rd_cnt/wr_cnt/err_cnt completion counters.
module dmem_ctrl #(
    parameter int DEPTH_LOG2 = 10,
    parameter int RD_LAT     = 1,
    parameter int ADDR_W     = 32
) (
    input  logic              clka,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              ready,
    output logic              stall,
    output logic              misalign
`ifdef DMEM_PERF_CNT_EN
    ,
    output logic [31:0]       rd_cnt,
    output logic [31:0]       wr_cnt,
    output logic [31:0]       err_cnt
`endif
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t                  state_q, state_d;
    logic [1:0]              cnt_q, cnt_d;
    logic [1:0]              lane_q, size_q;
    logic                    sx_q, we_q, mis_q;
    logic [31:0]             word_q;
    logic [31:0]             mem [DEPTH];

    logic                    accept, mis_in;
    logic [DEPTH_LOG2-1:0]   idx;
    logic [3:0]              be;
    logic [31:0]             wd, sh, ext;
    logic                    unused_addr;

    assign accept      = (state_q == IDLE) && req && !rst;
    assign idx         = addr[DEPTH_LOG2+1:2];
    assign unused_addr = ^addr[ADDR_W-1:DEPTH_LOG2+2];
    assign mis_in      = (size == 2'b11) || ((size == 2'b01) && addr[0]) ||
                         ((size == 2'b10) && (addr[1:0] != 2'b00));

    always_comb begin
        be = 4'b0000;
        wd = wdata;
        case (size)
            2'b00: begin be = 4'b0001 << addr[1:0]; wd = {4{wdata[7:0]}};  end
            2'b01: begin be = addr[1] ? 4'b1100 : 4'b0011; wd = {2{wdata[15:0]}}; end
            2'b10: be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    // Stores land at the accept edge; loads register the whole word for later lane select.
    always_ff @(posedge clka) begin
        if (accept && !mis_in) begin
            if (we) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
                end
            end else begin
                word_q <= mem[idx];
            end
        end
    end

    always_ff @(posedge clka) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            lane_q  <= 2'd0;
            size_q  <= 2'd0;
            sx_q    <= 1'b0;
            we_q    <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                lane_q <= addr[1:0];
                size_q <= size;
                sx_q   <= sign_ext;
                we_q   <= we;
                mis_q  <= mis_in;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (mis_in || we || (RD_LAT == 1)) begin
                        state_d = DONE;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 2'(RD_LAT - 2);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 2'd0) state_d = DONE;
                else               cnt_d   = cnt_q - 2'd1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign sh = word_q >> {lane_q, 3'b000};

    always_comb begin
        ext = word_q;
        case (size_q)
            2'b00:   ext = {{24{sx_q & sh[7]}},  sh[7:0]};
            2'b01:   ext = {{16{sx_q & sh[15]}}, sh[15:0]};
            default: ext = word_q;
        endcase
    end

    assign ready    = (state_q == DONE) && !rst;
    assign stall    = !rst && (((state_q == IDLE) && req) || (state_q == WAIT));
    assign misalign = ready && mis_q;
    assign rdata    = (ready && !mis_q && !we_q) ? ext : 32'd0;

`ifdef DMEM_PERF_CNT_EN
    logic [31:0] rd_cnt_q, wr_cnt_q, err_cnt_q;

    always_ff @(posedge clka) begin
        if (rst) begin
            rd_cnt_q  <= 32'd0;
            wr_cnt_q  <= 32'd0;
            err_cnt_q <= 32'd0;
        end else if (state_q == DONE) begin
            if (mis_q)     err_cnt_q <= err_cnt_q + 32'd1;
            else if (we_q) wr_cnt_q  <= wr_cnt_q + 32'd1;
            else           rd_cnt_q  <= rd_cnt_q + 32'd1;
        end
    end

    assign rd_cnt  = rd_cnt_q;
    assign wr_cnt  = wr_cnt_q;
    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench: two controllers (RD_LAT=1 with 16 words, RD_LAT=3 with 256 words) against a byte-array model.
module tb_dmem_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        a_req, a_we, a_sx, b_req, b_we, b_sx;
    logic [1:0]  a_size, b_size;
    logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
    logic [31:0] a_rdata, b_rdata;
    logic        a_ready, a_stall, a_mis, b_ready, b_stall, b_mis;
`ifdef DMEM_PERF_CNT_EN
    logic [31:0] a_rd_cnt, a_wr_cnt, a_err_cnt, b_rd_cnt, b_wr_cnt, b_err_cnt;
    int          prd = 0, pwr = 0, perr = 0;
`endif

    dmem_ctrl #(.DEPTH_LOG2(4), .RD_LAT(1), .ADDR_W(32)) u_a (
        .clka(clk), .rst(rst), .req(a_req), .we(a_we), .size(a_size), .sign_ext(a_sx),
        .addr(a_addr), .wdata(a_wdata), .rdata(a_rdata), .ready(a_ready), .stall(a_stall),
        .misalign(a_mis)
`ifdef DMEM_PERF_CNT_EN
        , .rd_cnt(a_rd_cnt), .wr_cnt(a_wr_cnt), .err_cnt(a_err_cnt)
`endif
    );

    dmem_ctrl #(.DEPTH_LOG2(8), .RD_LAT(3), .ADDR_W(32)) u_b (
        .clka(clk), .rst(rst), .req(b_req), .we(b_we), .size(b_size), .sign_ext(b_sx),
        .addr(b_addr), .wdata(b_wdata), .rdata(b_rdata), .ready(b_ready), .stall(b_stall),
        .misalign(b_mis)
`ifdef DMEM_PERF_CNT_EN
        , .rd_cnt(b_rd_cnt), .wr_cnt(b_wr_cnt), .err_cnt(b_err_cnt)
`endif
    );

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        logic        chk;
        int          ns;
    } exp_t;

    exp_t       qa[$], qb[$];
    logic [7:0] ma[64];
    logic [7:0] mb[1024];
    int         sc[2];
    int         checks = 0, passes = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s @%0t: got %h want %h", nm, $time, act, exp);
    endtask

    function automatic logic rdy(input int s);
        return (s == 0) ? a_ready : b_ready;
    endfunction

    // Reference model: bytes at addr..addr+n-1 (mod RAM size), little-endian.
    task automatic access(input int s, input logic w, input logic [1:0] sz, input logic sx,
                          input logic [31:0] ad, input logic [31:0] wd);
        exp_t        e;
        logic        mis, got;
        logic [31:0] v;
        int          nb, base, bytes;
        bytes = (s == 0) ? 64 : 1024;
        mis   = (sz == 2'd3) || (sz == 2'd1 && ad[0]) || (sz == 2'd2 && ad[1:0] != 2'd0);
        nb    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        base  = int'(ad & 32'(bytes - 1));
        e.mis = mis; e.chk = !w || mis; e.rdata = 32'd0;
        e.ns  = (w || mis) ? 1 : ((s == 0) ? 1 : 3);
        if (!mis) begin
            if (w) begin
                for (int k = 0; k < nb; k++) begin
                    if (s == 0) ma[base+k] = wd[8*k +: 8];
                    else        mb[base+k] = wd[8*k +: 8];
                end
            end else begin
                v = 32'd0;
                for (int k = 0; k < nb; k++) v[8*k +: 8] = (s == 0) ? ma[base+k] : mb[base+k];
                if (sz == 2'd0 && sx && v[7])  v = v | 32'hFFFF_FF00;
                if (sz == 2'd1 && sx && v[15]) v = v | 32'hFFFF_0000;
                e.rdata = v;
            end
        end
`ifdef DMEM_PERF_CNT_EN
        if (s == 0) begin
            if (mis) perr++; else if (w) pwr++; else prd++;
        end
`endif
        if (s == 0) begin
            qa.push_back(e);
            a_req = 1'b1; a_we = w; a_size = sz; a_sx = sx; a_addr = ad; a_wdata = wd;
        end else begin
            qb.push_back(e);
            b_req = 1'b1; b_we = w; b_size = sz; b_sx = sx; b_addr = ad; b_wdata = wd;
        end
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rdy(s)) begin got = 1'b1; break; end
        end
        if (!got) begin
            chk("ready_timeout", {31'd0, got}, 32'd1);
            if (s == 0 && qa.size() > 0) void'(qa.pop_back());
            if (s == 1 && qb.size() > 0) void'(qb.pop_back());
        end
        @(posedge clk); #1;
        if (s == 0) a_req = 1'b0; else b_req = 1'b0;
    endtask

    task automatic mon(input int s);
        logic        r, st, m;
        logic [31:0] d;
        exp_t        e;
        r  = (s == 0) ? a_ready : b_ready;
        st = (s == 0) ? a_stall : b_stall;
        m  = (s == 0) ? a_mis   : b_mis;
        d  = (s == 0) ? a_rdata : b_rdata;
        if (rst) begin
            chk("rst_ready", {31'd0, r}, 32'd0);
            chk("rst_stall", {31'd0, st}, 32'd0);
            sc[s] = 0;
            return;
        end
        if (st) sc[s]++;
        if (r) begin
            if ((s == 0 && qa.size() == 0) || (s == 1 && qb.size() == 0)) begin
                chk("spurious_ready", {31'd0, r}, 32'd0);
            end else begin
                e = (s == 0) ? qa.pop_front() : qb.pop_front();
                chk("stall_cycles", 32'(sc[s]), 32'(e.ns));
                chk("misalign", {31'd0, m}, {31'd0, e.mis});
                if (e.chk) chk("rdata", d, e.rdata);
            end
            sc[s] = 0;
        end
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    initial begin
        sc[0] = 0; sc[1] = 0;
        rst = 1'b1;
        a_req = 1'b1; a_we = 1'b0; a_size = 2'd2; a_sx = 1'b0; a_addr = 32'd0; a_wdata = 32'd0;
        b_req = 1'b1; b_we = 1'b0; b_size = 2'd2; b_sx = 1'b0; b_addr = 32'd0; b_wdata = 32'd0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_rdata_a", a_rdata, 32'd0);
            chk("rst_mis_b", {31'd0, b_mis}, 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0; a_req = 1'b0; b_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // RD_LAT=1, 16-word RAM
        access(0, 1'b1, 2'd2, 1'b0, 32'h10, 32'h8000_00F1);
        access(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        access(0, 1'b1, 2'd2, 1'b0, 32'h10, 32'h1122_3344);
        access(0, 1'b1, 2'd0, 1'b0, 32'h13, 32'h0000_00AB);
        access(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        access(0, 1'b0, 2'd0, 1'b1, 32'h13, 32'h0);
        access(0, 1'b0, 2'd0, 1'b0, 32'h13, 32'h0);
        access(0, 1'b1, 2'd2, 1'b0, 32'h20, 32'h0123_4567);
        access(0, 1'b1, 2'd1, 1'b0, 32'h22, 32'h0000_BEEF);
        access(0, 1'b0, 2'd1, 1'b1, 32'h22, 32'h0);
        access(0, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
        access(0, 1'b1, 2'd2, 1'b0, 32'h14, 32'h1234_5678);
        access(0, 1'b1, 2'd2, 1'b0, 32'h15, 32'hDEAD_BEEF);
        access(0, 1'b1, 2'd3, 1'b0, 32'h14, 32'hDEAD_BEEF);
        access(0, 1'b0, 2'd1, 1'b0, 32'h15, 32'h0);
        access(0, 1'b0, 2'd2, 1'b0, 32'h14, 32'h0);
        access(0, 1'b1, 2'd2, 1'b0, 32'h44, 32'h5A5A_5A5A);
        access(0, 1'b0, 2'd2, 1'b0, 32'h04, 32'h0);
        for (int w = 0; w < 16; w++) access(0, 1'b1, 2'd2, 1'b0, 32'(w * 4), $urandom);
        for (int i = 0; i < 60; i++)
            access(0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   $urandom, $urandom);

        // RD_LAT=3, 256-word RAM
        for (int w = 0; w < 16; w++) access(1, 1'b1, 2'd2, 1'b0, 32'h40 + 32'(w * 4), $urandom);
        access(1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
        b_req = 1'b1; b_we = 1'b0; b_size = 2'd2; b_addr = 32'h40;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1; b_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("no_ready_after_rst", {31'd0, b_ready}, 32'd0);
        end
        @(posedge clk); #1;
        access(1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
        for (int i = 0; i < 30; i++)
            access(1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   32'h40 + 32'($urandom_range(0, 63)) + ($urandom << 10), $urandom);

        repeat (3) @(posedge clk);
`ifdef DMEM_PERF_CNT_EN
        @(negedge clk);
        chk("rd_cnt", a_rd_cnt, 32'(prd));
        chk("wr_cnt", a_wr_cnt, 32'(pwr));
        chk("err_cnt", a_err_cnt, 32'(perr));
`endif
        if (qa.size() != 0 || qb.size() != 0)
            chk("queue_drained", 32'(qa.size() + qb.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
